// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher round sequencer: one 128-bit state register and a
// round counter. The block does one inverse round per cycle and reads round keys by index.
module aes_inv_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  output logic [3:0]   rk_idx,
  input  logic [0:127] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);

  typedef logic [0:127] block_t;
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} fsm_e;

  // The round counter and rk_idx are 4 bits wide, and FINAL is reached from round 1.
  if (NR < 2 || NR > 15) begin : g_bad_nr
    $error("aes_inv_round_ctrl: NR must be in 2..15");
  end

  localparam logic [3:0] NrIdx = 4'(NR);

  // Byte k of a block is row k%4, column k/4. Byte 0 sits at bits 0:7.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = '0;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc ^= sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // The multiplicative inverse is x^254. It maps 0 to 0, as AES requires.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] a;
    a = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  function automatic block_t inv_shift_rows(input block_t s);
    block_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[8*(r+4*c) +: 8] = s[8*(r+4*((c-r+4)%4)) +: 8];
    return o;
  endfunction

  function automatic block_t inv_sub_bytes(input block_t s);
    block_t o;
    for (int k = 0; k < 16; k++) o[8*k +: 8] = inv_sbox(s[8*k +: 8]);
    return o;
  endfunction

  function automatic block_t inv_mix_columns(input block_t s);
    block_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[32*c +: 8];
      a1 = s[32*c+8 +: 8];
      a2 = s[32*c+16 +: 8];
      a3 = s[32*c+24 +: 8];
      o[32*c    +: 8] = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
      o[32*c+8  +: 8] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
      o[32*c+16 +: 8] = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
      o[32*c+24 +: 8] = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);
    end
    return o;
  endfunction

  fsm_e       fsm_q, fsm_d;
  block_t     state_q, state_d;
  block_t     res_q, res_d;
  logic [3:0] round_q, round_d;
  block_t     core;
  block_t     mixed;

  assign core  = inv_sub_bytes(inv_shift_rows(state_q)) ^ rk_data;
  assign mixed = inv_mix_columns(core);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples values from before the edge, whatever order the processes run in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fsm_q <= S_IDLE;
    else       fsm_q <= fsm_d;
  end

  // NOTE: each always_comb assigns a default first so that no path infers a latch.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:  if (in_valid)          fsm_d = S_ROUND;
      S_ROUND: if (round_q == 4'd1)   fsm_d = S_FINAL;
      S_FINAL:                        fsm_d = S_DONE;
      S_DONE:  if (out_ready)         fsm_d = S_IDLE;
      default:                        fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = NrIdx;
    case (fsm_q)
      S_IDLE:  in_ready = 1'b1;
      S_ROUND: begin busy = 1'b1; rk_idx = round_q; end
      S_FINAL: begin busy = 1'b1; rk_idx = 4'd0;    end
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // The result is a separate register, so out_data moves only when DONE is entered.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    res_d   = res_q;
    case (fsm_q)
      S_IDLE: if (in_valid) begin
        state_d = in_data ^ rk_data;
        round_d = NrIdx - 4'd1;
      end
      S_ROUND: begin
        state_d = mixed;
        round_d = round_q - 4'd1;
      end
      S_FINAL: begin
        state_d = core;
        res_d   = core;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= '0;
      res_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      round_q <= round_d;
    end
  end

  assign out_data = res_q;

endmodule
